// File: rtl/alu_mc.sv
// Multi-cycle RV32I ALU with valid/ready handshakes, status flags and optional 1-bit/cycle shifter.
// The result register doubles as the shift working register while a serial shift is in flight.
module alu_mc #(
   parameter int unsigned WIDTH        = 32,
   parameter bit          SERIAL_SHIFT = 1'b1,
   parameter int unsigned SHW          = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [3:0]       alu_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpSub  = 4'd1;
   localparam logic [3:0] OpAnd  = 4'd2;
   localparam logic [3:0] OpOr   = 4'd3;
   localparam logic [3:0] OpXor  = 4'd4;
   localparam logic [3:0] OpSlt  = 4'd5;
   localparam logic [3:0] OpSltu = 4'd6;
   localparam logic [3:0] OpSll  = 4'd7;
   localparam logic [3:0] OpSrl  = 4'd8;
   localparam logic [3:0] OpSra  = 4'd9;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;

   logic             accept;
   logic [SHW-1:0]   shamt;
   logic             is_sub;
   logic             is_shift;
   logic             serial_go;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] step;

   assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign result    = res_q;
   assign zero      = zero_q;
   assign negative  = neg_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

   // Single-cycle datapath on the live inputs; only used on the accept edge.
   always_comb begin
      shamt    = srcB[SHW-1:0];
      is_sub   = (alu_ctrl == OpSub);
      is_shift = (alu_ctrl == OpSll) || (alu_ctrl == OpSrl) || (alu_ctrl == OpSra);
      serial_go = SERIAL_SHIFT && is_shift && (shamt != '0);
      b_eff    = is_sub ? ~srcB : srcB;
      sum      = {1'b0, srcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (alu_ctrl)
         OpAdd, OpSub: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            // Overflow when both addends share a sign that the sum does not.
            alu_v   = (srcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
         end
         OpAnd:  alu_res = srcA & srcB;
         OpOr:   alu_res = srcA | srcB;
         OpXor:  alu_res = srcA ^ srcB;
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
         OpSll:  alu_res = srcA << shamt;
         OpSrl:  alu_res = srcA >> shamt;
         OpSra:  alu_res = $signed(srcA) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (op_q)
         OpSll:   step = {res_q[WIDTH-2:0], 1'b0};
         OpSra:   step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
         default: step = {1'b0, res_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      op_d    = op_q;

      case (state_q)
         StShift: begin
            res_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
               state_d = StDone;
               zero_d  = (step == '0);
               neg_d   = step[WIDTH-1];
               carry_d = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         StDone: begin
            if (out_ready && !in_valid) state_d = StIdle;
         end
         default: ;
      endcase

      if (accept) begin
         op_d = alu_ctrl;
         if (serial_go) begin
            state_d = StShift;
            res_d   = srcA;
            cnt_d   = shamt;
         end else begin
            state_d = StDone;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            neg_d   = alu_res[WIDTH-1];
            carry_d = alu_c;
            ovf_d   = alu_v;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         res_q   <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc (WIDTH=32, SERIAL_SHIFT=1) against an arithmetic model.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic [3:0]  alu_ctrl = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero, negative, carry, overflow, busy;

   int n_checks = 0;
   int n_errors = 0;
   bit [31:0] exp_r;

   alu_mc #(.WIDTH(32), .SERIAL_SHIFT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .srcA(srcA), .srcB(srcB), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the operands.
   task automatic model(input bit [31:0] a, input bit [31:0] b, input bit [3:0] op,
                        output bit [31:0] r, output bit c, output bit v, output int lat);
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint lim = 64'sd2147483648;
      longint unsigned us;
      longint ss;
      int sh = int'(b % 32);
      r = '0; c = 1'b0; v = 1'b0; lat = 1;
      case (op)
         4'd0: begin us = ua + ub; r = us[31:0]; c = us[32]; ss = sa + sb;
                     v = (ss >= lim) || (ss < -lim); end
         4'd1: begin us = ua - ub; r = us[31:0]; c = (ua >= ub); ss = sa - sb;
                     v = (ss >= lim) || (ss < -lim); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd6: r = (ua < ub) ? 32'd1 : 32'd0;
         4'd7: begin us = ua << sh; r = us[31:0]; lat = (sh == 0) ? 1 : sh; end
         4'd8: begin r = a >> sh; lat = (sh == 0) ? 1 : sh; end
         4'd9: begin ss = sa >>> sh; r = ss[31:0]; lat = (sh == 0) ? 1 : sh; end
         default: r = '0;
      endcase
   endtask

   // Issue one op from IDLE and wait for its result; leaves the DUT in DONE.
   task automatic issue(input bit [31:0] a, input bit [31:0] b, input bit [3:0] op);
      bit [31:0] r; bit c, v; int lat, n;
      model(a, b, op, r, c, v, lat);
      exp_r = r;
      @(negedge clk);
      check("ready_before", in_ready, 1);
      srcA = a; srcB = b; alu_ctrl = op; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      srcA = $urandom; srcB = $urandom; alu_ctrl = 4'($urandom);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!out_valid && n == 1) check("ready_in_shift", in_ready, 0);
      end while (!out_valid && n < 64);
      check("latency", n, lat);
      check("result", result, r);
      check("zero", zero, (r == 0));
      check("negative", negative, r[31]);
      check("carry", carry, c);
      check("overflow", overflow, v);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("consumed", out_valid, 0);
   endtask

   initial begin
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {zero, negative, carry, overflow}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(32'h0000_0001, 32'h0000_0010, 4'd0); consume();
      issue(32'h7FFF_FFFF, 32'h0000_0001, 4'd0); consume();
      issue(32'hFFFF_FFFF, 32'h0000_0001, 4'd0); consume();
      issue(32'd5, 32'd7, 4'd1); consume();
      issue(32'hFFFF_FFFF, 32'd1, 4'd5); consume();
      issue(32'hFFFF_FFFF, 32'd1, 4'd6); consume();
      issue(32'h8000_0000, 32'd4, 4'd9); consume();
      issue(32'h1234_5678, 32'd0, 4'd7); consume();
      issue(32'h1234_5678, 32'd7, 4'd12); consume();

      // Backpressure, then back-to-back accept on the consuming edge.
      issue(32'hDEAD_BEEF, 32'h0000_1111, 4'd3);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_result", result, exp_r);
         check("bp_ready", in_ready, 0);
         check("bp_valid", out_valid, 1);
      end
      srcA = 32'hFF00_FF00; srcB = 32'h0F0F_0F0F; alu_ctrl = 4'd4;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("b2b_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b_valid", out_valid, 1);
      check("b2b_result", result, 32'hF00F_F00F);
      consume();

      // Reset in the middle of a long serial shift.
      @(negedge clk);
      srcA = 32'hA5A5_A5A5; srcB = 32'd20; alu_ctrl = 4'd8; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mrst_valid", out_valid, 0);
      check("mrst_result", result, 0);
      check("mrst_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (out_valid) check("stale_output", out_valid, 0);
      end
      check("post_rst_busy", busy, 0);

      for (int i = 0; i < 60; i++) begin
         bit [31:0] a = $urandom;
         bit [31:0] b = $urandom;
         bit [3:0] op = 4'($urandom_range(0, 15));
         if (i % 4 == 0) a = {a[31], 31'h0} | (b & 32'h1);
         if (op >= 4'd7 && op <= 4'd9 && (i % 3 == 0)) b = b & 32'h7;
         issue(a, b, op);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            check("rnd_hold", result, exp_r);
         end
         consume();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit ALU adder; sits in the RISC-V execute stage between the register-file read and the writeback mux.
- Supports the RV32I ALU op set, adds status flags, and uses a valid/ready handshake on both input and output.
- Shifts run either single-cycle or serially at 1 bit/cycle, selected by parameter, to save area on small FPGAs.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of 2, at least 8.
- SERIAL_SHIFT, 1, 1 = shifts take 1 bit per cycle; 0 = barrel shift in a single cycle.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op this cycle.
- srcA  in  WIDTH  operand A.
- srcB  in  WIDTH  operand B; shift amount is srcB[SHW-1:0].
- alu_ctrl  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10-15 reserved.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry-out. SUB: 1 when srcA >= srcB unsigned (no borrow). Otherwise 0.
- overflow  out  1  signed overflow for ADD/SUB; otherwise 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state = IDLE; in_ready=1; out_valid=0; result, all flags and the internal shift counter = 0. Reset asserted mid-shift or in DONE discards the op; no output is produced.
- An op is accepted on a rising edge with in_valid && in_ready. srcA, srcB and alu_ctrl are captured; later input changes have no effect on that op.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> DONE on accept for a non-shift op, a shift with shamt = 0, or any shift when SERIAL_SHIFT=0. Result and flags are registered on that edge.
- IDLE -> SHIFT on accept of SLL/SRL/SRA when SERIAL_SHIFT=1 and shamt != 0.
  - Load the working register with srcA and the counter with shamt.
  - Each cycle: shift 1 bit (SRA replicates the MSB); decrement the counter.
  - When the counter reaches 1, the final shift is applied and the state moves to DONE.
- Latency from the accept edge N: out_valid=1 after edge N+1, except serial shifts, which give out_valid after edge N+shamt.
- DONE: out_valid=1; result and flags stay stable while out_ready=0 (backpressure, unbounded hold).
- DONE with out_ready=1: the result is consumed on that edge. If in_valid is also 1, the new op is accepted on the same edge (back-to-back); otherwise the state returns to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is 0 in SHIFT.
- Arithmetic is modulo 2^WIDTH; SUB = srcA + ~srcB + 1.
- SLT / SLTU give a result of 0 or 1, zero-extended.
- Reserved opcodes: result 0, zero=1, the other flags 0, latency 1.
- Flags are registered together with result; zero and negative are valid for all ops.

Test Plan:
- Reset, then ADD srcA=0x00000001, srcB=0x00000010 -> out_valid 1 cycle after accept, result=0x00000011, zero=0, carry=0, overflow=0.
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, negative=1. ADD 0xFFFFFFFF + 0x00000001 -> result 0, carry=1, zero=1.
- SUB 5 - 7 -> result 0xFFFFFFFE, carry=0, negative=1. SLT 0xFFFFFFFF,1 -> 1. SLTU with the same operands -> 0.
- SERIAL_SHIFT=1: SRA 0x80000000 by 4 -> out_valid exactly 4 cycles after accept, result 0xF8000000, in_ready=0 while shifting. SLL by 0 -> result srcA with 1-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xFF00FF00, 0x0F0F0F0F) -> next result 0xF00FF00F, accepted on the same edge.
- Pulse rst_n low mid-SRL by 20 -> out_valid=0 and result=0 immediately; no stale output after reset is released.
